hazard_detect_unit: RTL and testbench
=====================================

# hazard_detect_unit

ID-stage hazard detection and destination tracker for the 5-stage MIPS pipeline. Tracks the destination register and write-back attributes of instructions in EX, MEM and WB, and stalls IF/ID with a bubble into ID/EX on a load-use dependency. It is also the producing end of the forwarding interface: it drives the MEM/WB destination and write-back-enable signals consumed by the EXE forwarding unit.

## Interface
- REG_ADDR_W, 5, register address width
- STALL_CNT_W, 16, stall counter width
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- ext_freeze  in  1  external hold of all stages (e.g. memory wait)
- id_valid  in  1  ID holds a real instruction (0 after flush)
- id_src1  in  5  source register 1
- id_src2  in  5  source register 2
- id_src2_used  in  1  src2 is read (R-type / branch compare)
- id_is_store  in  1  ID instruction is a store
- id_st_src  in  5  store-data source register
- id_dest  in  5  destination register
- id_wb_en  in  1  instruction writes the register file
- id_mem_read  in  1  instruction is a load
- stall  out  1  freeze PC and IF/ID; insert bubble into ID/EX
- dest_mem  out  5  destination of MEM-stage instruction
- wb_en_mem  out  1  MEM-stage instruction writes back
- dest_wb  out  5  destination of WB-stage instruction
- wb_en_wb  out  1  WB-stage instruction writes back
- stall_count  out  STALL_CNT_W  saturating count of stall cycles

## Operation
- Three tracking entries EX, MEM, WB; each holds {valid, dest, wb_en, mem_read}.
- Per cycle, when ext_freeze=0: EX <= (stall or !id_valid) ? bubble : ID fields; MEM <= EX; WB <= MEM. A bubble has all fields 0.
- ext_freeze=1: all entries and stall_count hold; stall is still computed.
- An entry "hazards" source s iff valid & wb_en & dest==s & s!=0. Register $0 never hazards.
- Sources checked: id_src1 always; id_src2 if id_src2_used; id_st_src if id_is_store. Only when id_valid=1.
- Load-use stall: EX entry has mem_read=1 and hazards any checked source.
- dest_mem/wb_en_mem and dest_wb/wb_en_wb: direct from MEM and WB entries (wb_en gated by valid).
- stall_count increments when stall=1 and ext_freeze=0; saturates at all-ones.

## Timing
- stall is combinational from ID inputs and registered EX entry; no same-cycle dependency on its own output.
- Load in ID at cycle n, dependent in ID at n+1: stall=1 at n+1; at n+2 load in MEM, bubble in EX, stall=0, dependent enters EX and forwards from MEM.
- Dependent two instructions after a load: no stall.
- Forwarding outputs are registered, valid one cycle after the instruction leaves the previous stage.
- Reset: all entries bubble, stall=0, dest_mem=dest_wb=0, wb_en_mem=wb_en_wb=0, stall_count=0. Reset mid-stall clears the stall the following cycle; reset overrides ext_freeze.

## Configuration
- FORWARDING_EN defined: behaviour above (load-use only, forwarding outputs driven).
- Undefined: stall whenever the EX or MEM entry hazards any checked source regardless of mem_read (WB writes first half-cycle, no stall); forwarding outputs tied to 0.

## Structure
- hazard_pkg: stage_entry_t struct {valid, dest, wb_en, mem_read}, BUBBLE constant, REG_ZERO constant.
- One sub-module hazard_match: combinational entry-vs-sources comparator, instantiated per tracked stage (EX, and MEM when FORWARDING_EN undefined).

## Test plan
- lw $2 then add $3,$2,$4 back-to-back -> stall=1 exactly one cycle, stall_count=1, then wb_en_mem=1, dest_mem=2 next cycle.
- lw $0 then add $3,$0,$1 -> stall=0 throughout.
- lw $5 then sw with id_st_src=5, id_src2_used=0 -> one-cycle stall; same with id_is_store=0 -> no stall.
- lw $7 then dependent with ext_freeze=1 for 3 cycles -> stall held high, stall_count unchanged, entries frozen; after release one counted stall.
- add $8 followed by dependent; build without FORWARDING_EN -> stall 2 cycles, count=2; with it -> 0 stalls.
- rst during stall -> next cycle stall=0, all forwarding outputs 0, count=0; stall_count at 16'hFFFF with further stalls stays 16'hFFFF.

Source files
------------

// File: rtl/hazard_detect_unit_pkg.sv
// hazard_pkg: pipeline tracking entry type and register-hazard helper shared by the hazard unit.
package hazard_pkg;
  localparam int REG_W = 5;
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             wb_en;
    logic             mem_read;
  } stage_entry_t;
  localparam stage_entry_t BUBBLE = '0;
  localparam logic [REG_W-1:0] REG_ZERO = '0;
  function automatic logic hits(input stage_entry_t e, input logic [REG_W-1:0] s);
    return e.valid && e.wb_en && e.dest == s && s != REG_ZERO;
  endfunction
endpackage

// File: rtl/hazard_detect_unit_match.sv
// hazard_match: flags when a tracked stage entry writes any source the ID instruction reads.
module hazard_match
  import hazard_pkg::*;
(
  input  stage_entry_t     entry,
  input  logic             id_valid,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic [REG_W-1:0] st_src,
  input  logic             src2_used,
  input  logic             is_store,
  output logic             hit
);
  assign hit = id_valid & (hits(entry, src1) | (src2_used & hits(entry, src2)) | (is_store & hits(entry, st_src)));
endmodule

// File: rtl/hazard_detect_unit.sv
// hazard_detect_unit: ID-stage stall generation and EX/MEM/WB destination tracking; FORWARDING_EN selects load-use-only stalls with forwarding outputs.
module hazard_detect_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ext_freeze,
  input  logic                   id_valid,
  input  logic [REG_ADDR_W-1:0]  id_src1,
  input  logic [REG_ADDR_W-1:0]  id_src2,
  input  logic                   id_src2_used,
  input  logic                   id_is_store,
  input  logic [REG_ADDR_W-1:0]  id_st_src,
  input  logic [REG_ADDR_W-1:0]  id_dest,
  input  logic                   id_wb_en,
  input  logic                   id_mem_read,
  output logic                   stall,
  output logic [REG_ADDR_W-1:0]  dest_mem,
  output logic                   wb_en_mem,
  output logic [REG_ADDR_W-1:0]  dest_wb,
  output logic                   wb_en_wb,
  output logic [STALL_CNT_W-1:0] stall_count
);
  stage_entry_t ex_q, mem_q, wb_q, id_e;
  logic ex_hit;
  assign id_e = '{valid: 1'b1, dest: id_dest, wb_en: id_wb_en, mem_read: id_mem_read};
  hazard_match u_ex (
    .entry(ex_q), .id_valid(id_valid), .src1(id_src1), .src2(id_src2), .st_src(id_st_src),
    .src2_used(id_src2_used), .is_store(id_is_store), .hit(ex_hit)
  );
`ifdef FORWARDING_EN
  assign stall     = ex_hit & ex_q.mem_read;
  assign dest_mem  = mem_q.dest;
  assign wb_en_mem = mem_q.valid & mem_q.wb_en;
  assign dest_wb   = wb_q.dest;
  assign wb_en_wb  = wb_q.valid & wb_q.wb_en;
`else
  logic mem_hit;
  // WB writes the register file in the first half-cycle, so only EX and MEM can stall
  hazard_match u_mem (
    .entry(mem_q), .id_valid(id_valid), .src1(id_src1), .src2(id_src2), .st_src(id_st_src),
    .src2_used(id_src2_used), .is_store(id_is_store), .hit(mem_hit)
  );
  assign stall     = ex_hit | mem_hit;
  assign dest_mem  = '0;
  assign wb_en_mem = 1'b0;
  assign dest_wb   = '0;
  assign wb_en_wb  = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= BUBBLE;
      mem_q       <= BUBBLE;
      wb_q        <= BUBBLE;
      stall_count <= '0;
    end else if (!ext_freeze) begin
      ex_q        <= (stall || !id_valid) ? BUBBLE : id_e;
      mem_q       <= ex_q;
      wb_q        <= mem_q;
      stall_count <= (stall && stall_count != '1) ? stall_count + 1'b1 : stall_count;
    end
  end
endmodule

// File: tb/tb_hazard_detect_unit.sv
// tb_hazard_detect_unit: directed and random stimulus against an instruction-history reference model.
module tb_hazard_detect_unit;
  logic clk = 1'b0;
  logic rst, ext_freeze, id_valid, id_src2_used, id_is_store, id_wb_en, id_mem_read;
  logic [4:0] id_src1, id_src2, id_st_src, id_dest;
  logic stall, wb_en_mem, wb_en_wb, s_stall, s_wb_en_mem, s_wb_en_wb;
  logic [4:0] dest_mem, dest_wb, s_dest_mem, s_dest_wb;
  logic [15:0] stall_count;
  logic [2:0] s_stall_count;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  hazard_detect_unit dut (
    .clk(clk), .rst(rst), .ext_freeze(ext_freeze), .id_valid(id_valid), .id_src1(id_src1),
    .id_src2(id_src2), .id_src2_used(id_src2_used), .id_is_store(id_is_store), .id_st_src(id_st_src),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .stall(stall),
    .dest_mem(dest_mem), .wb_en_mem(wb_en_mem), .dest_wb(dest_wb), .wb_en_wb(wb_en_wb),
    .stall_count(stall_count)
  );
  hazard_detect_unit #(.STALL_CNT_W(3)) sdut (
    .clk(clk), .rst(rst), .ext_freeze(ext_freeze), .id_valid(id_valid), .id_src1(id_src1),
    .id_src2(id_src2), .id_src2_used(id_src2_used), .id_is_store(id_is_store), .id_st_src(id_st_src),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .stall(s_stall),
    .dest_mem(s_dest_mem), .wb_en_mem(s_wb_en_mem), .dest_wb(s_dest_wb), .wb_en_wb(s_wb_en_wb),
    .stall_count(s_stall_count)
  );

  // Model: the last three instructions issued past ID (index 0 = EX), zeroed when a bubble was issued
  typedef struct {bit v; int d; bit w; bit m;} instr_t;
  instr_t hist[3];
  int cnt, cnt_s;
  bit exp_stall;

  function automatic bit writes(instr_t e, int s);
    return e.v && e.w && e.d == s && s != 0;
  endfunction

  function automatic bit model_stall();
    int srcs[$];
    if (!id_valid) return 0;
    srcs.push_back(int'(id_src1));
    if (id_src2_used) srcs.push_back(int'(id_src2));
    if (id_is_store) srcs.push_back(int'(id_st_src));
    foreach (srcs[k]) begin
`ifdef FORWARDING_EN
      if (hist[0].m && writes(hist[0], srcs[k])) return 1;
`else
      if (writes(hist[0], srcs[k]) || writes(hist[1], srcs[k])) return 1;
`endif
    end
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sense();
    #1;
    exp_stall = model_stall();
    chk("stall", {31'b0, stall}, {31'b0, exp_stall});
    chk("s_stall", {31'b0, s_stall}, {31'b0, exp_stall});
    chk("stall_count", {16'b0, stall_count}, cnt);
    chk("sat_count", {29'b0, s_stall_count}, cnt_s);
`ifdef FORWARDING_EN
    chk("dest_mem", {27'b0, dest_mem}, hist[1].d);
    chk("wb_en_mem", {31'b0, wb_en_mem}, {31'b0, hist[1].v && hist[1].w});
    chk("dest_wb", {27'b0, dest_wb}, hist[2].d);
    chk("wb_en_wb", {31'b0, wb_en_wb}, {31'b0, hist[2].v && hist[2].w});
`else
    chk("dest_mem", {27'b0, dest_mem}, 0);
    chk("wb_en_mem", {31'b0, wb_en_mem}, 0);
    chk("dest_wb", {27'b0, dest_wb}, 0);
    chk("wb_en_wb", {31'b0, wb_en_wb}, 0);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      foreach (hist[k]) hist[k] = '{0, 0, 0, 0};
      cnt = 0;
      cnt_s = 0;
    end else if (!ext_freeze) begin
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = (exp_stall || !id_valid) ? '{0, 0, 0, 0} : '{1, int'(id_dest), id_wb_en, id_mem_read};
      if (exp_stall) begin
        cnt = (cnt < 65535) ? cnt + 1 : cnt;
        cnt_s = (cnt_s < 7) ? cnt_s + 1 : cnt_s;
      end
    end
    @(negedge clk);
  endtask

  task automatic step();
    sense();
    tick();
  endtask

  task automatic ins(input bit v, input int s1, input int s2, input bit s2u, input bit st,
                     input int sts, input int d, input bit w, input bit m);
    id_valid = v; id_src1 = 5'(s1); id_src2 = 5'(s2); id_src2_used = s2u; id_is_store = st;
    id_st_src = 5'(sts); id_dest = 5'(d); id_wb_en = w; id_mem_read = m;
  endtask
  task automatic nop();             ins(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic lw(input int d, input int b); ins(1, b, 0, 0, 0, 0, d, 1, 1); endtask
  task automatic add(input int d, input int a, input int b); ins(1, a, b, 1, 0, 0, d, 1, 0); endtask

  initial begin
    rst = 1; ext_freeze = 0; nop();
    repeat (2) @(posedge clk);
    @(negedge clk);
    foreach (hist[k]) hist[k] = '{0, 0, 0, 0};
    cnt = 0; cnt_s = 0;
    step();
    chk("reset_stall", {31'b0, stall}, 0);
    chk("reset_count", {16'b0, stall_count}, 0);
    rst = 0;
    nop(); step();
    // lw $2 ; add $3,$2,$4
    lw(2, 1); step();
    add(3, 2, 4); sense();
    chk("lu_stall", {31'b0, stall}, 1);
    tick();
    repeat (3) step();
    nop(); repeat (3) step();
    // $0 never hazards
    lw(0, 1); step();
    add(3, 0, 1); sense();
    chk("r0_stall", {31'b0, stall}, 0);
    tick();
    nop(); repeat (3) step();
    // store data source
    lw(5, 1); step();
    ins(1, 1, 0, 0, 1, 5, 0, 0, 0); sense();
    chk("st_stall", {31'b0, stall}, 1);
    tick();
    nop(); repeat (3) step();
    lw(5, 1); step();
    ins(1, 1, 0, 0, 0, 5, 0, 0, 0); sense();
    chk("nost_stall", {31'b0, stall}, 0);
    tick();
    nop(); repeat (3) step();
    // freeze while stalled
    lw(7, 1); step();
    add(1, 7, 0); ext_freeze = 1;
    repeat (3) step();
    ext_freeze = 0;
    repeat (3) step();
    // ALU producer followed by dependent
    add(8, 1, 2); step();
    add(9, 8, 0); repeat (3) step();
    nop(); repeat (3) step();
    // reset mid-stall, overriding freeze
    lw(4, 1); step();
    add(6, 4, 4); step();
    ext_freeze = 1; rst = 1; step();
    ext_freeze = 0; rst = 0; sense();
    chk("rst_stall", {31'b0, stall}, 0);
    chk("rst_count", {16'b0, stall_count}, 0);
    tick();
    // saturate the narrow counter
    for (int i = 0; i < 10; i++) begin
      lw(1, 2); step();
      add(2, 1, 0); step(); step();
    end
    nop(); sense();
    chk("sat_final", {29'b0, s_stall_count}, 7);
    tick();
    // random traffic over a small register set for frequent hazards
    for (int i = 0; i < 400; i++) begin
      ins($urandom_range(9, 0) != 0, $urandom_range(3, 0), $urandom_range(3, 0), 1'($urandom),
          1'($urandom), $urandom_range(3, 0), $urandom_range(3, 0), 1'($urandom), 1'($urandom));
      ext_freeze = $urandom_range(9, 0) == 0;
      rst = $urandom_range(49, 0) == 0;
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
